// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, lookahead group size and op-code constants
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int CLA_GROUP = 4;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SLL = 4'h5,
        ALU_SRL = 4'h6,
        ALU_SRA = 4'h7,
        ALU_SLT = 4'h8
    } alu_op_e;

endpackage

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - 4-bit carry-lookahead adder slice with group propagate/generate
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       p_grp,
    output logic       g_grp
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = ci;
        // Every internal carry is a flat sum of products of the slice inputs.
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        p_grp = &p;
        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        c[4] = g_grp | (p_grp & ci);
        s    = p ^ c[3:0];
        co   = c[4];
    end

endmodule

// File: rtl/sub_32_bit.sv
// rtl/sub_32_bit.sv - registered Ra - Rb - cin via two-level CLA; SUB_32_BIT_OVERFLOW_EN adds ovf
module sub_32_bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SUB_32_BIT_OVERFLOW_EN
   ,output logic             ovf
`endif
);

    localparam int N = WIDTH / CLA_GROUP;

    logic [WIDTH-1:0] rb_n;
    logic             c0;
    logic [N:0]       c_grp;
    logic [N-1:0]     p_grp;
    logic [N-1:0]     g_grp;
    logic [N-1:0]     co_w;
    logic [WIDTH-1:0] diff;
    logic             unused_co;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    // Carry into group k, expanded from group P/G so no group waits on its neighbour.
    function automatic logic lookahead(input logic [N-1:0] p, input logic [N-1:0] g,
                                       input logic cz, input int k);
        logic c;
        logic run;
        run = cz;
        for (int j = 0; j < k; j++) run = run & p[j];
        c = run;
        for (int j = 0; j < k; j++) begin
            logic t;
            t = g[j];
            for (int m = j + 1; m < k; m++) t = t & p[m];
            c = c | t;
        end
        return c;
    endfunction

    assign rb_n = ~Rb;
    assign c0   = ~cin;

    always_comb begin
        c_grp = '0;
        for (int k = 0; k <= N; k++) c_grp[k] = lookahead(p_grp, g_grp, c0, k);
    end

    for (genvar i = 0; i < N; i++) begin : g_cla
        cla_4bit u_cla (
            .a     (Ra[i*CLA_GROUP +: CLA_GROUP]),
            .b     (rb_n[i*CLA_GROUP +: CLA_GROUP]),
            .ci    (c_grp[i]),
            .s     (diff[i*CLA_GROUP +: CLA_GROUP]),
            .co    (co_w[i]),
            .p_grp (p_grp[i]),
            .g_grp (g_grp[i])
        );
    end

    // Slice ripple carry-outs duplicate the lookahead carries and are not needed.
    assign unused_co = ^co_w;

    always_comb begin
        sum_d  = diff;
        cout_d = c_grp[N];
    end

`ifdef SUB_32_BIT_OVERFLOW_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = (Ra[WIDTH-1] != Rb[WIDTH-1]) && (diff[WIDTH-1] != Ra[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    always_ff @(posedge clk) begin
        if (clr) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_sub_32_bit.sv
// tb/tb_sub_32_bit.sv - self-checking bench for sub_32_bit, directed and random vectors
module tb_sub_32_bit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        cin_i;
    logic [31:0] sum_o;
    logic        cout_o;
`ifdef SUB_32_BIT_OVERFLOW_EN
    logic        ovf_o;
`endif

    int checks = 0;
    int errors = 0;

    sub_32_bit dut (
        .clk  (clk),
        .clr  (clr),
        .Ra   (ra),
        .Rb   (rb),
        .cin  (cin_i),
        .sum  (sum_o),
        .cout (cout_o)
`ifdef SUB_32_BIT_OVERFLOW_EN
       ,.ovf  (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the true mathematical difference.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic c,
                         output logic [31:0] s, output logic co, output logic ov);
        longint ud;
        longint sd;
        ud = longint'(a) - longint'(b) - longint'(c);
        sd = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
        s  = ud[31:0];
        co = (ud >= 0);
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endtask

    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        logic [31:0] es;
        logic        ec;
        logic        eo;
        @(negedge clk);
        clr = 1'b0; ra = a; rb = b; cin_i = c;
        @(posedge clk);
        #1;
        model(a, b, c, es, ec, eo);
        check({tag, "_sum"}, sum_o, es);
        check({tag, "_cout"}, {31'd0, cout_o}, {31'd0, ec});
`ifdef SUB_32_BIT_OVERFLOW_EN
        check({tag, "_ovf"}, {31'd0, ovf_o}, {31'd0, eo});
`endif
    endtask

    task automatic expect_const(input string tag, input logic [31:0] es, input logic ec);
        check({tag, "_sum_k"}, sum_o, es);
        check({tag, "_cout_k"}, {31'd0, cout_o}, {31'd0, ec});
    endtask

    initial begin
        clr = 1'b1; ra = 32'hDEAD_BEEF; rb = 32'h0000_1234; cin_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_const("reset", 32'h0, 1'b0);

        apply("t_small", 32'h0000_0024, 32'h0000_0001, 1'b0);
        expect_const("t_small", 32'h0000_0023, 1'b1);
        apply("t_borrow_in", 32'hFFFF_FFFF, 32'h0000_00FF, 1'b1);
        expect_const("t_borrow_in", 32'hFFFF_FEFF, 1'b1);
        apply("t_wrap", 32'h0000_0000, 32'h0000_0001, 1'b0);
        expect_const("t_wrap", 32'hFFFF_FFFF, 1'b0);
`ifdef SUB_32_BIT_OVERFLOW_EN
        check("t_wrap_ovf_k", {31'd0, ovf_o}, 32'd0);
`endif
        apply("t_minneg", 32'h8000_0000, 32'h0000_0001, 1'b0);
        expect_const("t_minneg", 32'h7FFF_FFFF, 1'b1);
`ifdef SUB_32_BIT_OVERFLOW_EN
        check("t_minneg_ovf_k", {31'd0, ovf_o}, 32'd1);
`endif
        apply("t_eq_c1", 32'h1234_5678, 32'h1234_5678, 1'b1);
        expect_const("t_eq_c1", 32'hFFFF_FFFF, 1'b0);
        apply("t_eq_c0", 32'h1234_5678, 32'h1234_5678, 1'b0);
        expect_const("t_eq_c0", 32'h0, 1'b1);
        apply("t_carry_chain", 32'h0000_0000, 32'h0000_0000, 1'b1);
        expect_const("t_carry_chain", 32'hFFFF_FFFF, 1'b0);

        // clr held two cycles with live operands, then released
        @(negedge clk);
        clr = 1'b1; ra = 32'h5555_AAAA; rb = 32'h0000_0011; cin_i = 1'b0;
        @(posedge clk); #1;
        expect_const("clr_c1", 32'h0, 1'b0);
        @(posedge clk); #1;
        expect_const("clr_c2", 32'h0, 1'b0);
        apply("after_clr", 32'h5555_AAAA, 32'h0000_0011, 1'b0);
        expect_const("after_clr", 32'h5555_AA99, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = (i % 10 == 0) ? a : $urandom();
            if (i % 7 == 0) b = b >> $urandom_range(31, 0);
            apply("rand", a, b, 1'($urandom_range(1, 0)));
            if (i == 100) begin
                @(negedge clk);
                clr = 1'b1; ra = $urandom(); rb = $urandom();
                @(posedge clk); #1;
                expect_const("clr_mid", 32'h0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
